sync_mod_counter: RTL and testbench
===================================

Name: sync_mod_counter

Overview:
Parametrised, fully synchronous successor to the team's 4-bit ripple counter. All bits update on one clock edge, so there is no ripple skew. Features:
- Programmable modulus
- Up/down direction
- Parallel load
- Count enable
- Continuous or one-shot run mode, controlled by a small FSM
- Combinational carry/borrow output for cascading counters into wider chains

Used as a timebase, event counter and prescaler.

Parameters:
WIDTH, 4, counter width in bits; legal 1..32.
MODULUS, 16, count sequence length; legal 2..2**WIDTH; counts span 0..MODULUS-1.

Ports:
clk  input  1  rising-edge clock.
rstn  input  1  synchronous active-low reset.
start  input  1  level, sampled each cycle; IDLE/DONE -> RUN.
stop  input  1  level, sampled each cycle; RUN/DONE -> IDLE; q is held.
en  input  1  count enable, qualified by RUN state.
up_dn  input  1  1 = count up, 0 = count down.
oneshot  input  1  1 = stop at terminal value; 0 = wrap continuously.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  load value.
q  output  WIDTH  registered count.
busy  output  1  registered; 1 while in RUN.
done  output  1  registered; 1 while in DONE.
carry_out  output  1  combinational; 1 when a terminal-value step will occur this cycle.

Behaviour:
- Reset and clocking:
  - Single clock domain. Reset is synchronous and active-low on rstn.
  - When rstn=0 at a rising edge: q=0, state=IDLE, busy=0, done=0.
  - Reset has the highest priority and overrides a mid-run count or load.
- Terminal value (TV): MODULUS-1 when up_dn=1; 0 when up_dn=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: q holds. start=1 -> RUN.
  - RUN: count step when en=1, otherwise q holds.
    - stop=1 -> IDLE.
    - If oneshot=1 and a count step occurs with q==TV: q holds at TV (no wrap) and the FSM goes to DONE.
  - DONE: q holds.
    - start=1 -> RUN, and q is set to the opposite endpoint: 0 for up, MODULUS-1 for down.
    - stop=1 -> IDLE.
  - start and stop both 1: stop wins.
- Count step (RUN, en=1, load=0):
  - Up: q==MODULUS-1 -> 0, else q+1.
  - Down: q==0 -> MODULUS-1, else q-1.
  - up_dn may change on any cycle; it takes effect on the next step, with no extra latency.
- Load:
  - load=1 has priority over count, start-reload and hold, in every state.
  - q <= load_val. If load_val >= MODULUS, q <= MODULUS-1 (clamp).
  - Load does not change FSM state, except when it coincides with a start/stop transition; the transition still occurs.
- carry_out = (state==RUN) & en & ~load & (q==TV).
  - It asserts in the same cycle as the wrap (or oneshot terminal).
  - Cascading: connect it to the next stage's en.
- Latency:
  - q changes on the edge after inputs are sampled.
  - busy/done follow the state register and become visible 1 cycle after start/stop.
- Boundaries:
  - MODULUS=2**WIDTH: wrap is a natural overflow.
  - MODULUS<2**WIDTH: q never exceeds MODULUS-1.

Optional Feature:
Macro SYNC_MOD_COUNTER_GRAY_EN.
- Defined: adds output q_gray [WIDTH-1:0], a registered gray code of the next q. It is updated on the same edge as q, so q_gray == q ^ (q>>1) every cycle. Reset value is 0.
- Undefined: port absent, no extra logic; all other behaviour is identical.

Test Plan:
- Reset and hold: WIDTH=4, MODULUS=16. rstn=0 for 2 cycles, then 1, with start=0 -> q=0, busy=0, done=0; q stays 0 for 20 cycles despite en=1.
- Continuous up wrap: start pulse, en=1, up_dn=1, oneshot=0. Check after 15 edges: q=15 and carry_out=1. Check on the next edge: q=0 and carry_out=0.
- Modulus-10 down: MODULUS=10, up_dn=0, starting from q=0 -> q goes 9,8,..,0,9. carry_out=1 only while q=0 and en=1.
- Oneshot: MODULUS=10, up, oneshot=1, run from 0 -> q holds at 9, done=1, busy=0. A start pulse then gives q=0 and busy=1 the next cycle.
- Load priority and clamp: MODULUS=10. In RUN, drive load=1 with load_val=13 and en=1 -> q=9, state stays RUN. Same cycle as rstn=0 -> q=0.
- Control conflicts: start=stop=1 in IDLE -> stays IDLE. stop while in RUN at q=5 -> IDLE, q=5. With GRAY_EN defined, q_gray==q^(q>>1) every cycle of all of the above.

Source files
------------

// File: rtl/sync_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_mod_counter
// Description : Synchronous modulo-N up/down counter with load, enable and an
//               IDLE/RUN/DONE run-mode FSM. Define SYNC_MOD_COUNTER_GRAY_EN
//               to add the registered q_gray output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_mod_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             carry_out
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] C_MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] w_tv;
    logic             w_at_tv;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;

    always_comb begin
        w_tv       = up_dn ? C_MAX_VAL : '0;
        w_at_tv    = (count_q == w_tv);
        w_load_val = (64'(load_val) >= MODULUS) ? C_MAX_VAL : load_val;
        // At the terminal value the step lands on the opposite endpoint.
        if (w_at_tv)
            w_step_val = up_dn ? '0 : C_MAX_VAL;
        else
            w_step_val = up_dn ? (count_q + C_ONE) : (count_q - C_ONE);
    end

    assign carry_out = (state_q == ST_RUN) & en & ~load & w_at_tv;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (en && !load) begin
                    if (oneshot && w_at_tv)
                        state_d = ST_DONE;
                    else
                        count_d = w_step_val;
                end
            end
            ST_DONE: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (start) begin
                    state_d = ST_RUN;
                    count_d = up_dn ? '0 : C_MAX_VAL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Load overrides every count/reload source but never blocks a transition.
        if (load)
            count_d = w_load_val;
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = count_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SYNC_MOD_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    // Encoding the next count keeps q_gray aligned with q on the same edge.
    always_comb begin
        gray_d = count_d ^ (count_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            gray_q <= '0;
        else
            gray_q <= gray_d;
    end

    assign q_gray = gray_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_mod_counter.sv
`default_nettype none
// Scoreboard bench: modulus-16 and modulus-10 counters share one stimulus stream
// and are checked each cycle against an arithmetic reference model.
module tb_sync_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, stop, en, up_dn, oneshot, load;
    logic [3:0] load_val;
    logic [1:0][3:0] dq;
    logic [1:0]      dbusy, ddone, dcarry;
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    logic [1:0][3:0] dgray;
`endif

    sync_mod_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .oneshot(oneshot), .load(load), .load_val(load_val),
        .q(dq[0]), .busy(dbusy[0]), .done(ddone[0]), .carry_out(dcarry[0])
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        , .q_gray(dgray[0])
`endif
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .en(en),
        .up_dn(up_dn), .oneshot(oneshot), .load(load), .load_val(load_val),
        .q(dq[1]), .busy(dbusy[1]), .done(ddone[1]), .carry_out(dcarry[1])
`ifdef SYNC_MOD_COUNTER_GRAY_EN
        , .q_gray(dgray[1])
`endif
    );

    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    typedef struct {
        logic [1:0][3:0] q;
        logic [1:0]      b;
        logic [1:0]      d;
        logic [1:0]      c;
        bit              ck_carry;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mods[2] = '{16, 10};
    int   m_q[2]    = '{0, 0};
    int   m_mode[2] = '{M_IDLE, M_IDLE};
    bit   known = 1'b0;

    task automatic check(input string name, input int k, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut=m%0d t=%0t actual=%0h required=%0h", name, mods[k], $time, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic e_i,
                         input logic u, input logic o, input logic l, input logic [3:0] lv);
        exp_t x;
        int   tv;
        @(negedge clk);
        rstn = r; start = s; stop = p; en = e_i; up_dn = u; oneshot = o; load = l; load_val = lv;
        x.ck_carry = known;
        for (int k = 0; k < 2; k++) begin
            tv = u ? mods[k] - 1 : 0;
            x.c[k] = (m_mode[k] == M_RUN) && e_i && !l && (m_q[k] == tv);
            if (!r) begin
                m_q[k] = 0;
                m_mode[k] = M_IDLE;
            end else begin
                if (m_mode[k] == M_IDLE) begin
                    if (s && !p) m_mode[k] = M_RUN;
                end else if (m_mode[k] == M_RUN) begin
                    if (p) m_mode[k] = M_IDLE;
                    else if (e_i && !l) begin
                        if (o && m_q[k] == tv) m_mode[k] = M_DONE;
                        else m_q[k] = u ? (m_q[k] + 1) % mods[k] : (m_q[k] + mods[k] - 1) % mods[k];
                    end
                end else begin
                    if (p) m_mode[k] = M_IDLE;
                    else if (s) begin
                        m_mode[k] = M_RUN;
                        m_q[k] = u ? 0 : mods[k] - 1;
                    end
                end
                if (l) m_q[k] = (int'(lv) >= mods[k]) ? mods[k] - 1 : int'(lv);
            end
            x.q[k] = 4'(m_q[k]);
            x.b[k] = (m_mode[k] == M_RUN);
            x.d[k] = (m_mode[k] == M_DONE);
        end
        if (!r) known = 1'b1;
        sb.push_back(x);
    endtask

    task automatic run(input int n, input logic s, input logic p, input logic e_i,
                       input logic u, input logic o);
        for (int i = 0; i < n; i++) drive(1'b1, s, p, e_i, u, o, 1'b0, 4'd0);
    endtask

    // Monitor: carry is sampled just after inputs settle, registered outputs just after the edge.
    initial begin : monitor
        exp_t       x;
        logic [1:0] cs;
        forever begin
            @(negedge clk);
            #2;
            cs = dcarry;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check("q", k, dq[k], x.q[k]);
                    check("busy", k, {3'b0, dbusy[k]}, {3'b0, x.b[k]});
                    check("done", k, {3'b0, ddone[k]}, {3'b0, x.d[k]});
                    if (x.ck_carry) check("carry_out", k, {3'b0, cs[k]}, {3'b0, x.c[k]});
`ifdef SYNC_MOD_COUNTER_GRAY_EN
                    check("q_gray", k, dgray[k], x.q[k] ^ (x.q[k] >> 1));
`endif
                end
            end
        end
    end

    initial begin : stimulus
        logic u, o;
        rstn = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
        up_dn = 1'b1; oneshot = 1'b0; load = 1'b0; load_val = 4'd0;

        // reset, then idle hold with en high
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        run(20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // continuous up with wrap
        run(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run(20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // down from 0 through the wrap
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        run(12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // oneshot up to terminal, then restart from DONE
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        run(18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run(3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        // load clamp in RUN, then load coinciding with reset
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        run(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        // start+stop together in IDLE, stop mid-run at 5
        run(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        u = 1'b1;
        o = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) u = ~u;
            if ($urandom_range(0, 31) == 0) o = ~o;
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                  u, o, $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
